// File: rtl/neigh_dist_topk.sv
// neigh_dist_topk: squared-L2 distance pipeline that keeps a
// sorted list of the K closest distinct neighbours to a query.
module neigh_dist_topk #(
  parameter int DIM = 2,
  parameter int WIDTH = 16,
  parameter int K = 4,
  parameter int ID_W = 32,
  localparam int DW = 2*WIDTH+2+$clog2(DIM),
  localparam int CW = $clog2(K+1)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic signed [DIM-1:0][WIDTH-1:0] query_in,
  input  logic query_valid_in,
  input  logic [ID_W-1:0] cand_id_in,
  input  logic signed [DIM-1:0][WIDTH-1:0] cand_data_in,
  input  logic cand_valid_in,
  output logic cand_ready_out,
  input  logic fetch_done_in,
  output logic [K-1:0][ID_W-1:0] best_id_out,
  output logic [K-1:0][DW-1:0] best_dist_out,
  output logic [CW-1:0] best_count_out,
  output logic busy_out,
  output logic done_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [DIM-1:0][WIDTH-1:0] q;
  logic start, accept, drained;

  logic v1, v2, v3;
  logic [ID_W-1:0] id1, id2, id3;
  logic [WIDTH:0] diff1 [DIM];
  logic [2*WIDTH+1:0] sq2 [DIM];
  logic [DW-1:0] dist3;

  logic signed [2*WIDTH+1:0] ext [DIM];
  logic [DW-1:0] sum;

  logic dup, ins;
  logic [CW-1:0] pos, ncnt;
  logic [K-1:0][ID_W-1:0] nid;
  logic [K-1:0][DW-1:0] nd;

  assign start = query_valid_in
    && (state == IDLE || state == DONE);
  assign cand_ready_out = (state == RUN);
  assign accept = cand_valid_in && cand_ready_out;
  assign drained = !(v1 || v2 || v3);
  assign busy_out = (state == RUN) || (state == DRAIN);
  assign done_out = (state == DONE);

  // Search control and query latch.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      q <= '0;
    end else if (start) begin
      state <= RUN;
      q <= query_in;
    end else begin
      unique case (1'b1)
        (state == RUN && fetch_done_in): state <= DRAIN;
        (state == DRAIN && drained): state <= DONE;
        default: ;
      endcase
    end
  end

  // Square each lane difference at full width and sum the lanes.
  always_comb begin
    sum = '0;
    for (int d = 0; d < DIM; d++) begin
      ext[d] = (2*WIDTH+2)'($signed(diff1[d]));
      sum = sum + DW'(sq2[d]);
    end
  end

  // Three registered arithmetic stages, one candidate per cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      id1 <= '0;
      id2 <= '0;
      id3 <= '0;
      dist3 <= '0;
      for (int d = 0; d < DIM; d++) begin
        diff1[d] <= '0;
        sq2[d] <= '0;
      end
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      id1 <= cand_id_in;
      id2 <= id1;
      id3 <= id2;
      dist3 <= sum;
      for (int d = 0; d < DIM; d++) begin
        diff1[d] <= {cand_data_in[d][WIDTH-1], cand_data_in[d]}
          - {q[d][WIDTH-1], q[d]};
        sq2[d] <= unsigned'(ext[d] * ext[d]);
      end
    end
  end

  // Sorted insert: ties rank behind existing entries.
  always_comb begin
    dup = 1'b0;
    pos = '0;
    for (int i = 0; i < K; i++) begin
      if (CW'(i) < best_count_out) begin
        if (best_id_out[i] == id3) dup = 1'b1;
        if (best_dist_out[i] <= dist3) pos = pos + CW'(1);
      end
    end
    ins = v3 && !dup && (pos < CW'(K));
    nid = best_id_out;
    nd = best_dist_out;
    ncnt = best_count_out;
    if (ins) begin
      for (int i = 1; i < K; i++) begin
        if (CW'(i) > pos) begin
          nid[i] = best_id_out[i-1];
          nd[i] = best_dist_out[i-1];
        end
      end
      for (int i = 0; i < K; i++) begin
        if (CW'(i) == pos) begin
          nid[i] = id3;
          nd[i] = dist3;
        end
      end
      if (best_count_out != CW'(K))
        ncnt = best_count_out + CW'(1);
    end
  end

  // Candidate list; cleared when a new search starts.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      best_id_out <= '0;
      best_dist_out <= '0;
      best_count_out <= '0;
    end else if (start) begin
      best_id_out <= '0;
      best_dist_out <= '0;
      best_count_out <= '0;
    end else begin
      best_id_out <= nid;
      best_dist_out <= nd;
      best_count_out <= ncnt;
    end
  end

endmodule

// File: tb/tb_neigh_dist_topk.sv
// tb_neigh_dist_topk: table vectors, corner sequences and a
// randomized run against a queue-based top-K model.
module tb_neigh_dist_topk;

  logic clk_in = 1'b0;
  logic rst_in;
  logic [1:0][15:0] query_in;
  logic query_valid_in;
  logic [31:0] cand_id_in;
  logic [1:0][15:0] cand_data_in;
  logic cand_valid_in;
  logic cand_ready_out;
  logic fetch_done_in;
  logic [3:0][31:0] best_id_out;
  logic [3:0][34:0] best_dist_out;
  logic [2:0] best_count_out;
  logic busy_out;
  logic done_out;

  neigh_dist_topk dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .query_in(query_in),
    .query_valid_in(query_valid_in),
    .cand_id_in(cand_id_in),
    .cand_data_in(cand_data_in),
    .cand_valid_in(cand_valid_in),
    .cand_ready_out(cand_ready_out),
    .fetch_done_in(fetch_done_in),
    .best_id_out(best_id_out),
    .best_dist_out(best_dist_out),
    .best_count_out(best_count_out),
    .busy_out(busy_out),
    .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [15:0] qx;
    logic [15:0] qy;
    logic [2:0] n;
    logic [4:0][31:0] id;
    logic [4:0][15:0] x;
    logic [4:0][15:0] y;
    logic [2:0] cnt;
    logic [3:0][31:0] eid;
    logic [3:0][34:0] edist;
  } vec_t;

  typedef struct {
    longint d;
    int unsigned id;
  } ent_t;

  vec_t tbl [5];
  ent_t ml [$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic longint sqd(input int x, input int y,
                                 input int qx, input int qy);
    longint dx, dy;
    dx = longint'(x) - longint'(qx);
    dy = longint'(y) - longint'(qy);
    return dx*dx + dy*dy;
  endfunction

  task automatic model_add(input int unsigned id, input longint d);
    int p;
    ent_t e;
    foreach (ml[i]) if (ml[i].id == id) return;
    p = 0;
    foreach (ml[i]) if (ml[i].d <= d) p++;
    if (p < 4) begin
      e.d = d;
      e.id = id;
      ml.insert(p, e);
      if (ml.size() > 4) void'(ml.pop_back());
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, longint'(best_count_out),
        longint'(ml.size()));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s id%0d", tag, i), longint'(best_id_out[i]),
          (i < ml.size()) ? longint'(ml[i].id) : 0);
      chk($sformatf("%s dist%0d", tag, i),
          longint'(best_dist_out[i]),
          (i < ml.size()) ? ml[i].d : 0);
    end
  endtask

  task automatic start_query(input int qx, input int qy);
    query_in[0] = qx[15:0];
    query_in[1] = qy[15:0];
    query_valid_in = 1'b1;
    @(negedge clk_in);
    query_valid_in = 1'b0;
  endtask

  task automatic send(input int id, input int x, input int y,
                      input logic fd);
    chk("ready_in_run", longint'(cand_ready_out), 1);
    cand_id_in = id;
    cand_data_in[0] = x[15:0];
    cand_data_in[1] = y[15:0];
    cand_valid_in = 1'b1;
    fetch_done_in = fd;
    @(negedge clk_in);
    cand_valid_in = 1'b0;
    fetch_done_in = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (!done_out && cyc < 30) begin
      @(negedge clk_in);
      cyc++;
    end
    chk("done_reached", longint'(done_out), 1);
  endtask

  task automatic finish(input int hold, output int cyc);
    fetch_done_in = 1'b1;
    repeat (hold) @(negedge clk_in);
    fetch_done_in = 1'b0;
    cyc = hold;
    wait_done(cyc);
  endtask

  task automatic set_c(input int r, input int j, input int id,
                       input int x, input int y);
    tbl[r].id[j] = id;
    tbl[r].x[j] = x[15:0];
    tbl[r].y[j] = y[15:0];
  endtask

  task automatic set_e(input int r, input int j, input int id,
                       input longint d);
    tbl[r].eid[j] = id;
    tbl[r].edist[j] = d[34:0];
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int cyc, qx, qy, n, x, y, id;
    logic fd;

    for (int r = 0; r < 5; r++) tbl[r] = '0;
    // basic ordering
    tbl[0].n = 3;
    set_c(0, 0, 10, 3, 4);
    set_c(0, 1, 11, 1, 1);
    set_c(0, 2, 12, -2, 0);
    tbl[0].cnt = 3;
    set_e(0, 0, 11, 2);
    set_e(0, 1, 12, 4);
    set_e(0, 2, 10, 25);
    // overflow eviction
    tbl[1].n = 5;
    set_c(1, 0, 10, 3, 4);
    set_c(1, 1, 11, 1, 1);
    set_c(1, 2, 12, -2, 0);
    set_c(1, 3, 20, 1, 2);
    set_c(1, 4, 21, 0, 3);
    tbl[1].cnt = 4;
    set_e(1, 0, 11, 2);
    set_e(1, 1, 12, 4);
    set_e(1, 2, 20, 5);
    set_e(1, 3, 21, 9);
    // full list, worst 25, far candidate dropped
    tbl[2].n = 5;
    set_c(2, 0, 10, 3, 4);
    set_c(2, 1, 11, 1, 1);
    set_c(2, 2, 12, -2, 0);
    set_c(2, 3, 20, 1, 2);
    set_c(2, 4, 22, 10, 10);
    tbl[2].cnt = 4;
    set_e(2, 0, 11, 2);
    set_e(2, 1, 12, 4);
    set_e(2, 2, 20, 5);
    set_e(2, 3, 10, 25);
    // tie and duplicate
    tbl[3].n = 3;
    set_c(3, 0, 30, 2, 0);
    set_c(3, 1, 31, 0, -2);
    set_c(3, 2, 30, 1, 0);
    tbl[3].cnt = 2;
    set_e(3, 0, 30, 4);
    set_e(3, 1, 31, 4);
    // signed extremes
    tbl[4].qx = 16'h8000;
    tbl[4].qy = 16'h8000;
    tbl[4].n = 1;
    set_c(4, 0, 40, 32767, 32767);
    tbl[4].cnt = 1;
    set_e(4, 0, 40, 64'd8589672450);

    rst_in = 1'b0;
    query_in = '0;
    query_valid_in = 1'b0;
    cand_id_in = '0;
    cand_data_in = '0;
    cand_valid_in = 1'b0;
    fetch_done_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst count", longint'(best_count_out), 0);
    chk("rst ready", longint'(cand_ready_out), 0);
    chk("rst busy", longint'(busy_out), 0);
    chk("rst done", longint'(done_out), 0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // reset in the middle of a search
    start_query(0, 0);
    send(50, 1, 1, 1'b0);
    send(51, 2, 2, 1'b0);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("midrst count", longint'(best_count_out), 0);
    chk("midrst ready", longint'(cand_ready_out), 0);
    chk("midrst busy", longint'(busy_out), 0);
    chk("midrst done", longint'(done_out), 0);
    rst_in = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("midrst later count", longint'(best_count_out), 0);
    chk("midrst later id0", longint'(best_id_out[0]), 0);
    chk("midrst later busy", longint'(busy_out), 0);

    for (int r = 0; r < 5; r++) begin
      start_query(int'($signed(tbl[r].qx)), int'($signed(tbl[r].qy)));
      for (int j = 0; j < int'(tbl[r].n); j++)
        send(int'(tbl[r].id[j]), int'($signed(tbl[r].x[j])),
             int'($signed(tbl[r].y[j])), 1'b0);
      finish(1, cyc);
      chk($sformatf("t%0d done_lat_ok", r),
          longint'(cyc >= 4 && cyc <= 5), 1);
      chk($sformatf("t%0d count", r), longint'(best_count_out),
          longint'(tbl[r].cnt));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t%0d id%0d", r, i),
            longint'(best_id_out[i]), longint'(tbl[r].eid[i]));
        chk($sformatf("t%0d dist%0d", r, i),
            longint'(best_dist_out[i]), longint'(tbl[r].edist[i]));
      end
    end

    // intermediate eviction, query ignored in RUN, restart
    ml.delete();
    start_query(0, 0);
    send(10, 3, 4, 1'b0);
    model_add(10, 25);
    send(11, 1, 1, 1'b0);
    model_add(11, 2);
    send(12, -2, 0, 1'b0);
    model_add(12, 4);
    send(20, 1, 2, 1'b0);
    model_add(20, 5);
    repeat (4) @(negedge clk_in);
    check_model("mid");
    chk("mid busy", longint'(busy_out), 1);
    query_in[0] = 16'd100;
    query_in[1] = 16'd100;
    query_valid_in = 1'b1;
    @(negedge clk_in);
    query_valid_in = 1'b0;
    chk("ignore busy", longint'(busy_out), 1);
    chk("ignore count", longint'(best_count_out), 4);
    send(21, 0, 3, 1'b0);
    model_add(21, 9);
    finish(3, cyc);
    check_model("evict");
    query_in = '0;
    query_valid_in = 1'b1;
    @(negedge clk_in);
    query_valid_in = 1'b0;
    chk("restart count", longint'(best_count_out), 0);
    chk("restart busy", longint'(busy_out), 1);
    chk("restart done", longint'(done_out), 0);
    chk("restart id0", longint'(best_id_out[0]), 0);
    chk("restart dist0", longint'(best_dist_out[0]), 0);
    finish(1, cyc);
    chk("empty count", longint'(best_count_out), 0);

    // randomized searches
    for (int r = 0; r < 6; r++) begin
      ml.delete();
      if (r % 2 == 1) begin
        qx = int'($urandom_range(0, 4)) - 2;
        qy = int'($urandom_range(0, 4)) - 2;
      end else begin
        qx = int'(shortint'($urandom()));
        qy = int'(shortint'($urandom()));
      end
      start_query(qx, qy);
      n = int'($urandom_range(12, 20));
      fd = 1'b0;
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk_in);
        id = int'($urandom_range(1, 12));
        if (r % 2 == 1) begin
          x = int'($urandom_range(0, 6)) - 3;
          y = int'($urandom_range(0, 6)) - 3;
        end else begin
          x = int'(shortint'($urandom()));
          y = int'(shortint'($urandom()));
        end
        fd = (j == n-1) && (r % 3 == 0);
        send(id, x, y, fd);
        model_add(id, sqd(x, y, qx, qy));
      end
      if (fd) begin
        cyc = 0;
        wait_done(cyc);
        chk($sformatf("r%0d fd_same_cycle_lat", r),
            longint'(cyc >= 4 && cyc <= 5), 1);
      end else begin
        finish(int'($urandom_range(1, 3)), cyc);
      end
      check_model($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/neigh_dist_topk.md
Name: neigh_dist_topk

Overview:
- Sits directly downstream of graph_fetch: consumes each fetched neighbour (ID plus DIM-lane feature vector) and computes its squared L2 distance to a latched query vector.
- Keeps a sorted list of the K closest distinct neighbours.
- Reports done once the fetcher signals full fetch and the pipeline has drained.
- The next-hop selector reads the list.

Parameters:
DIM, 2, number of feature lanes per vertex
WIDTH, 16, signed bit width of each feature lane
K, 4, depth of the best-candidate list
ID_W, 32, neighbour ID width (matches graph_fetch address width)
DW (localparam), 2*WIDTH+2+$clog2(DIM), distance width

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous reset, active-low
query_in  input  [DIM-1:0][WIDTH] signed  query vector
query_valid_in  input  1  latch query, clear list, start search
cand_id_in  input  ID_W  neighbour ID (graph_fetch neigh_fifo_out)
cand_data_in  input  [DIM-1:0][WIDTH] signed  neighbour features
cand_valid_in  input  1  candidate present (AND of all lane valids, formed by the parent)
cand_ready_out  output  1  candidate accepted when valid&&ready
fetch_done_in  input  1  graph_fetch fully_fetched_out
best_id_out  output  [K-1:0][ID_W]  sorted IDs, index 0 closest
best_dist_out  output  [K-1:0][DW]  matching distances
best_count_out  output  $clog2(K+1)  valid entries, 0..K
busy_out  output  1  state RUN or DRAIN
done_out  output  1  high while state DONE

Behaviour:
- Reset (rst_in low, asynchronous):
  - state IDLE; all list entries 0; best_count_out 0.
  - cand_ready_out, busy_out, done_out all 0.
  - Pipeline valid bits cleared.
  - Reset mid-search aborts the search with no partial result retained.
- FSM:
  - IDLE/DONE + query_valid_in -> RUN. Next edge: latch query_in; best_count_out=0; entries zeroed.
  - RUN: cand_ready_out=1. fetch_done_in -> DRAIN; cand_ready_out drops the cycle after. A candidate presented together with fetch_done_in is still accepted.
  - DRAIN: cand_ready_out=0. When all pipeline valid bits are 0 -> DONE.
  - DONE: done_out=1, list frozen. query_valid_in restarts.
  - query_valid_in in RUN/DRAIN is ignored.
- Pipeline (no stalls, 1 candidate/cycle), all stages registered with a valid bit:
  - S1: diff[d] = cand_data[d] - query[d], sign-extended to WIDTH+1.
  - S2: sq[d] = diff[d]*diff[d], unsigned 2*WIDTH+2.
  - S3: dist = sum of sq[d], DW bits, no overflow possible.
  - S4: list update.
  - List reflects a candidate 4 cycles after its accept edge.
- List update (single cycle):
  - If the ID is already in entries 0..count-1: drop, no change.
  - Otherwise compute pos = number of valid entries with dist <= new dist. Ties keep older entries ahead.
  - If pos < K: entries pos..K-2 shift down one, the new entry is written at pos, and count saturates at K. The old entry K-1 is discarded when the list is full.
  - If pos == K: drop.
- Entries at index >= best_count_out read as 0.
- fetch_done_in held high over multiple cycles is harmless.
- DONE is reached no earlier than 4 cycles after the last accept.

Test Plan:
1. Basic ordering. DIM=2, K=4, query (0,0); feed id10 (3,4), id11 (1,1), id12 (-2,0) back-to-back, then fetch_done_in. Required: ids [11,12,10], dists [2,4,25], count=3, done_out high within 5 cycles of the last accept.
2. Overflow eviction. Query (0,0); add id20 (1,2)=5 and id21 (0,3)=9. Required: list [11,12,10] becomes [11,12,20,10], then [11,12,20,21]; id10 is evicted and count stays 4. Separately, with a full list whose worst entry is 25, id22 (10,10)=200 is dropped.
3. Duplicate and tie handling.
   - id30 (2,0)=4, then id31 (0,-2)=4, then id30 (1,0) again. Required: [30,31], dists [4,4]; the duplicate is ignored.
4. Signed extremes. WIDTH=16, query (-32768,-32768), candidate (32767,32767). Required: dist = 2*65535^2 = 8589672450, no wrap in DW=35 bits.
5. Reset mid-search. Accept 2 candidates, pull rst_in low for 1 cycle. Required: count 0, state IDLE, ready 0; a new query_valid_in works normally.
6. Restart and ignore. query_valid_in during RUN has no effect. In DONE, a new query clears the list within 1 cycle and busy_out rises.
